bomb_scheduler: RTL and testbench
=================================

BOMB_SCHEDULER -- requirements
Module: bomb_scheduler

Interface
REQ-001 Parameter NB, 4: bomb table slots.
REQ-002 Parameter FUSE, 3: ticks from placement to detonation.
REQ-003 Parameter HOLD, 2: ticks an explosion stays displayed before clearing.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 tick  in  1  one-cycle timebase pulse.
REQ-007 req_p1, req_p2  in  1  bomb placement request; held until granted.
REQ-008 pos_p1, pos_p2  in  8  target cell; addr = row*16+col, row=addr[7:4], col=addr[3:0].
REQ-009 len_p1, len_p2  in  3  explosion arm length, 1..7; 0 treated as 1.
REQ-010 gnt_p1, gnt_p2  out  1  one-cycle grant pulse, asserted in the cycle the BOMB_UN write issues.
REQ-011 rd_addr  out  8  wall lookup address; rd_wall  in  3  combinational wall code for rd_addr (0 = empty).
REQ-012 wr_en  out  1; wr_addr  out  8; wr_data  out  3  bomb-grid write port, one write per cycle.
REQ-013 busy  out  1  high when FSM not in S_IDLE.

Function
REQ-014 Bomb-grid codes: EMPTY=0, BOMB_UN=2, EXP_UP=3, EXP_DOWN=4, EXP_LEFT=5, EXP_RIGHT=6, EXP_CEN=7.
REQ-015 Slot states: FREE, LIVE (fuse counter), BURNT (hold counter); each slot stores pos, len, four 3-bit extents.
REQ-016 On tick, every LIVE fuse and BURNT hold counter decrements, saturating at 0, in any FSM state.
REQ-017 FSM states: S_IDLE, S_PLACE, S_EXP, S_CLR; only S_IDLE selects work.
REQ-018 S_IDLE priority: BURNT slot with hold=0 -> S_CLR; else LIVE slot with fuse=0 -> S_EXP; else grantable request -> S_PLACE; lowest slot index wins within a class.
REQ-019 Grantable: a free slot exists and pos matches no LIVE/BURNT slot; otherwise the request stays pending with no grant.
REQ-020 Both players grantable: round-robin, the player not granted last wins; reset favours p1.
REQ-021 S_PLACE lasts 1 cycle: write BOMB_UN at pos, pulse gnt, load slot LIVE with fuse=FUSE, len, extents=0; return to S_IDLE.
REQ-022 S_EXP cycle 1 writes EXP_CEN at center; then directions UP, DOWN, LEFT, RIGHT in order, step k=1..len.
REQ-023 Per step: if the next cell is off-grid (row/col wrap) or rd_wall!=0, the cycle writes nothing and the direction ends; else write direction code and set extent=k; a direction ends after writing step len.
REQ-024 Cycles in S_EXP = 1 + sum over directions of (extent + (extent<len ? 1:0)).
REQ-025 Chain reaction: an arm write onto a LIVE slot's pos forces that slot's fuse to 0 (detonates later via REQ-018).
REQ-026 S_EXP exit: slot becomes BURNT with hold=HOLD; return to S_IDLE.
REQ-027 S_CLR writes EMPTY to center plus every recorded extent cell, one per cycle, same order, 1+sum(extents) cycles; slot becomes FREE.
REQ-028 rd_addr presents the candidate cell during S_EXP steps; 0 otherwise.
REQ-029 wr_en low in S_IDLE; wr_addr/wr_data 0 when wr_en low.
REQ-030 fuse=0 reached during S_EXP/S_CLR/S_PLACE is served after return to S_IDLE; no slot is lost or double-processed.

Reset
REQ-031 reset_n low at a clock edge: all slots FREE, FSM S_IDLE, wr_en/gnt_p1/gnt_p2/busy 0, round-robin to p1, within one cycle, aborting any operation.
REQ-032 Grid contents written before reset are not cleaned by this block.

Verification
REQ-033 req_p1 pos=0x88 len=2, empty walls -> gnt_p1 pulse with BOMB_UN@0x88; after 3 ticks EXP_CEN@0x88, UP@0x78,0x68, DOWN@0x98,0xA8, LEFT@0x87,0x86, RIGHT@0x89,0x8A over 9 cycles; after 2 ticks EMPTY writes to same 9 cells.
REQ-034 pos=0x00 len=3 -> UP and LEFT end with zero writes, DOWN 0x10,0x20,0x30, RIGHT 0x01,0x02,0x03; S_EXP lasts 9 cycles.
REQ-035 Wall at 0x89, bomb 0x88 len=2 -> RIGHT writes nothing; clear pass never writes 0x89.
REQ-036 req_p1 and req_p2 asserted same cycle, distinct pos, repeated -> grants alternate p1, p2, p1; fifth bomb with NB=4 waits until a slot frees.
REQ-037 Bomb A 0x88 len=2, bomb B 0x8A placed later -> A's RIGHT arm forces B to detonate on the next S_IDLE selection, before B's own fuse expires.
REQ-038 reset_n low mid-S_EXP -> next cycle wr_en=0, busy=0; new request granted in S_PLACE normally.

Source files
------------

// File: rtl/bomb_scheduler.sv
// rtl/bomb_scheduler.sv - bomb placement, detonation and explosion-clear scheduler
module bomb_scheduler #(
  parameter int NB   = 4,
  parameter int FUSE = 3,
  parameter int HOLD = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       req_p1,
  input  logic       req_p2,
  input  logic [7:0] pos_p1,
  input  logic [7:0] pos_p2,
  input  logic [2:0] len_p1,
  input  logic [2:0] len_p2,
  output logic       gnt_p1,
  output logic       gnt_p2,
  output logic [7:0] rd_addr,
  input  logic [2:0] rd_wall,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [2:0] wr_data,
  output logic       busy
);
  localparam int SW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [15:0] FUSE_V = 16'(FUSE);
  localparam logic [15:0] HOLD_V = 16'(HOLD);

  typedef enum logic [1:0] {S_IDLE, S_PLACE, S_EXP, S_CLR} state_t;
  typedef enum logic [1:0] {SL_FREE, SL_LIVE, SL_BURNT} slot_t;

  state_t        state;
  slot_t         sl_st  [NB];
  logic [15:0]   sl_cnt [NB];   // fuse while LIVE, hold while BURNT
  logic [7:0]    sl_pos [NB];
  logic [2:0]    sl_len [NB];   // stored already normalised to 1..7
  logic [2:0]    sl_ext [NB][4];

  logic [SW-1:0] cur;
  logic [2:0]    dir;           // 0 = centre, 1..4 = UP, DOWN, LEFT, RIGHT
  logic [2:0]    step;
  logic [7:0]    pl_pos;
  logic [2:0]    pl_len;
  logic          prefer_p2;

  logic [7:0]    cen;
  logic [1:0]    di;
  logic [2:0]    cur_ext;
  logic [4:0]    row, col, k5, nrow, ncol;
  logic          off_grid, blocked, in_step;
  logic [7:0]    cand;

  assign cen     = sl_pos[cur];
  assign di      = 2'(dir - 3'd1);
  assign cur_ext = sl_ext[cur][di];
  assign in_step = (state == S_EXP) && (dir != 3'd0);
  assign blocked = off_grid || (rd_wall != 3'd0);
  assign rd_addr = in_step ? cand : 8'd0;
  assign busy    = (state != S_IDLE);

  // Candidate cell step cells away from the centre; off_grid flags row/col wrap
  always_comb begin
    row      = {1'b0, cen[7:4]};
    col      = {1'b0, cen[3:0]};
    k5       = {2'b00, step};
    nrow     = row;
    ncol     = col;
    off_grid = 1'b0;
    case (dir)
      3'd1: begin off_grid = (row < k5); nrow = row - k5; end
      3'd2: begin nrow = row + k5; off_grid = (nrow > 5'd15); end
      3'd3: begin off_grid = (col < k5); ncol = col - k5; end
      3'd4: begin ncol = col + k5; off_grid = (ncol > 5'd15); end
      default: ;
    endcase
    cand = {nrow[3:0], ncol[3:0]};
  end

  // Grid write port, decoded from the current FSM position
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = 8'd0;
    wr_data = 3'd0;
    case (state)
      S_PLACE: begin wr_en = 1'b1; wr_addr = pl_pos; wr_data = 3'd2; end
      S_EXP: begin
        if (dir == 3'd0) begin
          wr_en = 1'b1; wr_addr = cen; wr_data = 3'd7;
        end else if (!blocked) begin
          wr_en = 1'b1; wr_addr = cand; wr_data = 3'(dir + 3'd2);
        end
      end
      S_CLR: begin wr_en = 1'b1; wr_addr = (dir == 3'd0) ? cen : cand; wr_data = 3'd0; end
      default: ;
    endcase
  end

  logic          clr_hit, exp_hit, free_hit, conf1, conf2, g1, g2, pick_p2;
  logic [SW-1:0] clr_idx, exp_idx, free_idx;
  logic [2:0]    clr_nd;

  // Work selection (lowest index wins) and next non-empty arm for the clear pass
  always_comb begin
    clr_hit  = 1'b0; exp_hit = 1'b0; free_hit = 1'b0; conf1 = 1'b0; conf2 = 1'b0;
    clr_idx  = '0;   exp_idx = '0;   free_idx = '0;
    clr_nd   = 3'd0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (sl_st[i] == SL_BURNT && sl_cnt[i] == 16'd0) begin clr_hit = 1'b1; clr_idx = SW'(i); end
      if (sl_st[i] == SL_LIVE && sl_cnt[i] == 16'd0) begin exp_hit = 1'b1; exp_idx = SW'(i); end
      if (sl_st[i] == SL_FREE) begin free_hit = 1'b1; free_idx = SW'(i); end
      if (sl_st[i] != SL_FREE && sl_pos[i] == pos_p1) conf1 = 1'b1;
      if (sl_st[i] != SL_FREE && sl_pos[i] == pos_p2) conf2 = 1'b1;
    end
    for (int d = 4; d >= 1; d--)
      if (d > int'(dir) && sl_ext[cur][d-1] != 3'd0) clr_nd = 3'(d);
  end

  assign g1      = req_p1 && free_hit && !conf1;
  assign g2      = req_p2 && free_hit && !conf2;
  assign pick_p2 = g2 && (!g1 || prefer_p2);

  // Slot table, timers and scheduling FSM
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cur       <= '0;
      dir       <= 3'd0;
      step      <= 3'd0;
      pl_pos    <= 8'd0;
      pl_len    <= 3'd0;
      prefer_p2 <= 1'b0;
      gnt_p1    <= 1'b0;
      gnt_p2    <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        sl_st[i]  <= SL_FREE;
        sl_cnt[i] <= 16'd0;
        sl_pos[i] <= 8'd0;
        sl_len[i] <= 3'd0;
        for (int j = 0; j < 4; j++) sl_ext[i][j] <= 3'd0;
      end
    end else begin
      gnt_p1 <= 1'b0;
      gnt_p2 <= 1'b0;
      if (tick)
        for (int i = 0; i < NB; i++)
          if (sl_st[i] != SL_FREE && sl_cnt[i] != 16'd0) sl_cnt[i] <= sl_cnt[i] - 16'd1;
      case (state)
        S_IDLE: begin
          if (clr_hit) begin
            state <= S_CLR; cur <= clr_idx; dir <= 3'd0; step <= 3'd0;
          end else if (exp_hit) begin
            state <= S_EXP; cur <= exp_idx; dir <= 3'd0; step <= 3'd0;
          end else if (g1 || g2) begin
            state     <= S_PLACE;
            cur       <= free_idx;
            pl_pos    <= pick_p2 ? pos_p2 : pos_p1;
            pl_len    <= pick_p2 ? ((len_p2 == 3'd0) ? 3'd1 : len_p2)
                                 : ((len_p1 == 3'd0) ? 3'd1 : len_p1);
            gnt_p1    <= !pick_p2;
            gnt_p2    <= pick_p2;
            prefer_p2 <= !pick_p2;
          end
        end
        S_PLACE: begin
          sl_st[cur]  <= SL_LIVE;
          sl_cnt[cur] <= FUSE_V;
          sl_pos[cur] <= pl_pos;
          sl_len[cur] <= pl_len;
          for (int j = 0; j < 4; j++) sl_ext[cur][j] <= 3'd0;
          state <= S_IDLE;
        end
        S_EXP: begin
          if (dir == 3'd0) begin
            dir <= 3'd1; step <= 3'd1;
          end else begin
            if (!blocked) begin
              sl_ext[cur][di] <= step;
              // an arm reaching another live bomb lights its fuse immediately
              for (int i = 0; i < NB; i++)
                if (sl_st[i] == SL_LIVE && sl_pos[i] == cand) sl_cnt[i] <= 16'd0;
            end
            if (blocked || step == sl_len[cur]) begin
              if (dir == 3'd4) begin
                sl_st[cur] <= SL_BURNT; sl_cnt[cur] <= HOLD_V; state <= S_IDLE; dir <= 3'd0;
              end else begin
                dir <= dir + 3'd1; step <= 3'd1;
              end
            end else begin
              step <= step + 3'd1;
            end
          end
        end
        S_CLR: begin
          if (dir != 3'd0 && step < cur_ext) begin
            step <= step + 3'd1;
          end else if (clr_nd != 3'd0) begin
            dir <= clr_nd; step <= 3'd1;
          end else begin
            sl_st[cur] <= SL_FREE; sl_cnt[cur] <= 16'd0; state <= S_IDLE; dir <= 3'd0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bomb_scheduler.sv
// tb/tb_bomb_scheduler.sv - scoreboard bench for bomb_scheduler with a cell-level reference model
module tb_bomb_scheduler;
  localparam int NB = 4, FUSE = 3, HOLD = 2;

  logic       clk = 1'b0, reset_n = 1'b0, tick = 1'b0, req_p1 = 1'b0, req_p2 = 1'b0;
  logic [7:0] pos_p1 = 8'd0, pos_p2 = 8'd0;
  logic [2:0] len_p1 = 3'd0, len_p2 = 3'd0;
  logic       gnt_p1, gnt_p2, wr_en, busy;
  logic [7:0] rd_addr, wr_addr;
  logic [2:0] rd_wall, wr_data;

  logic [2:0]  wall_map [256];
  logic [12:0] sb [$];           // {addr, data, gnt_p1, gnt_p2}
  int          m_addr [$];
  int          m_code [$];
  int          m_cyc;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;
  assign rd_wall = wall_map[rd_addr];

  bomb_scheduler #(.NB(NB), .FUSE(FUSE), .HOLD(HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick),
    .req_p1(req_p1), .req_p2(req_p2), .pos_p1(pos_p1), .pos_p2(pos_p2),
    .len_p1(len_p1), .len_p2(len_p2), .gnt_p1(gnt_p1), .gnt_p2(gnt_p2),
    .rd_addr(rd_addr), .rd_wall(rd_wall), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy)
  );

  // Monitor: every grid write is popped against the scoreboard
  always @(negedge clk) begin : mon
    logic [12:0] got, want;
    if (wr_en === 1'b1) begin
      got = {wr_addr, wr_data, gnt_p1, gnt_p2};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%h data=%0d gnt=%b%b required no write",
                 wr_addr, wr_data, gnt_p1, gnt_p2);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL write got addr=%h data=%0d gnt=%b%b required addr=%h data=%0d gnt=%b%b",
                   got[12:5], got[4:2], got[1], got[0], want[12:5], want[4:2], want[1], want[0]);
        end
      end
    end else if (gnt_p1 === 1'b1 || gnt_p2 === 1'b1) begin
      errors++;
      $display("FAIL gnt_without_write got gnt=%b%b required 00", gnt_p1, gnt_p2);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, want);
    end
  endtask

  task automatic do_tick();
    tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req_p1 = 1'b0; req_p2 = 1'b0; tick = 1'b0;
    cyc(2);
    sb.delete();
    reset_n = 1'b1;
  endtask

  task automatic clear_walls();
    foreach (wall_map[i]) wall_map[i] = 3'd0;
  endtask

  // Reference: centre, then each arm walks outward until off-grid, wall, or len cells
  task automatic build_model(input logic [7:0] pos, input logic [2:0] len);
    int L, r, c, n, rr, cc, a;
    int dr [4];
    int dc [4];
    dr = '{-1, 1, 0, 0};
    dc = '{0, 0, -1, 1};
    m_addr.delete(); m_code.delete();
    L = (len == 3'd0) ? 1 : int'(len);
    r = int'(pos[7:4]); c = int'(pos[3:0]);
    m_addr.push_back(int'(pos)); m_code.push_back(7);
    m_cyc = 1;
    for (int d = 0; d < 4; d++) begin
      n = 0;
      for (int k = 1; k <= L; k++) begin
        rr = r + dr[d] * k; cc = c + dc[d] * k;
        if (rr < 0 || rr > 15 || cc < 0 || cc > 15) break;
        a = rr * 16 + cc;
        if (wall_map[a] != 3'd0) break;
        m_addr.push_back(a); m_code.push_back(3 + d);
        n++;
      end
      m_cyc += n + ((n < L) ? 1 : 0);
    end
  endtask

  task automatic push_w(input int a, input int code, input bit g1, input bit g2);
    sb.push_back({8'(a), 3'(code), g1, g2});
  endtask

  task automatic push_exp();
    foreach (m_addr[i]) push_w(m_addr[i], m_code[i], 1'b0, 1'b0);
  endtask

  task automatic push_clr(input int cells [$]);
    foreach (cells[i]) push_w(cells[i], 0, 1'b0, 1'b0);
  endtask

  task automatic place(input bit p2, input logic [7:0] pos, input logic [2:0] len);
    int t = 0;
    push_w(int'(pos), 2, !p2, p2);
    if (p2) begin pos_p2 = pos; len_p2 = len; req_p2 = 1'b1; end
    else    begin pos_p1 = pos; len_p1 = len; req_p1 = 1'b1; end
    while (((p2 ? gnt_p2 : gnt_p1) !== 1'b1) && t < 100) begin cyc(1); t++; end
    check("grant_seen", int'(t < 100), 1);
    cyc(1);
    if (p2) req_p2 = 1'b0; else req_p1 = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int quiet = 0, t = 0;
    while (quiet < 4 && t < 400) begin
      cyc(1); t++;
      quiet = (busy === 1'b0) ? quiet + 1 : 0;
    end
    if (quiet < 4) begin
      errors++; checks++;
      $display("FAIL %s_idle_timeout got busy=%b required 0", name, busy);
    end
  endtask

  task automatic measure_busy(output int cycles);
    int t = 0;
    cycles = 0;
    while (busy !== 1'b1 && t < 50) begin cyc(1); t++; end
    while (busy === 1'b1 && cycles < 200) begin cyc(1); cycles++; end
  endtask

  // One bomb from placement through explosion to clear; writes are armed only
  // once the final tick is due, so an early detonation shows as an unexpected write
  task automatic bomb_cycle(input string name, input bit p2, input logic [7:0] pos, input logic [2:0] len);
    int got_cyc, want_cyc;
    int cells [$];
    build_model(pos, len);
    want_cyc = m_cyc;
    cells = m_addr;
    place(p2, pos, len);
    repeat (FUSE - 1) do_tick();
    cyc(3);
    push_exp();
    do_tick();
    measure_busy(got_cyc);
    check({name, "_exp_cycles"}, got_cyc, want_cyc);
    repeat (HOLD - 1) do_tick();
    cyc(3);
    push_clr(cells);
    do_tick();
    wait_idle(name);
    check({name, "_sb_drained"}, sb.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got no finish required finish");
    $fatal(1);
  end

  initial begin : main
    int   n_gnt, g1c, g2c, t, seen;
    int   a_cells [$];
    int   b_cells [$];
    int   c_cells [4][$];
    logic [7:0] rr_pos [4];

    clear_walls();
    do_reset();
    check("reset_wr_en", int'(wr_en), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_gnt", int'({gnt_p1, gnt_p2}), 0);

    bomb_cycle("centre", 1'b0, 8'h88, 3'd2);
    bomb_cycle("corner", 1'b0, 8'h00, 3'd3);
    bomb_cycle("len0", 1'b1, 8'hFF, 3'd0);
    wall_map[8'h89] = 3'd1;
    bomb_cycle("wall", 1'b1, 8'h88, 3'd2);
    clear_walls();

    // Round robin with both players pending, then a fifth bomb against a full table
    do_reset();
    rr_pos = '{8'h11, 8'h55, 8'h99, 8'hDD};
    push_w(8'h11, 2, 1'b1, 1'b0); push_w(8'h55, 2, 1'b0, 1'b1);
    push_w(8'h99, 2, 1'b1, 1'b0); push_w(8'hDD, 2, 1'b0, 1'b1);
    pos_p1 = 8'h11; pos_p2 = 8'h55; len_p1 = 3'd1; len_p2 = 3'd1;
    req_p1 = 1'b1; req_p2 = 1'b1;
    n_gnt = 0; g1c = 0; g2c = 0; t = 0;
    while (n_gnt < 4 && t < 200) begin
      cyc(1); t++;
      if (gnt_p1 === 1'b1) begin
        n_gnt++; g1c++;
        pos_p1 = (g1c == 1) ? 8'h99 : 8'h33;
      end
      if (gnt_p2 === 1'b1) begin
        n_gnt++; g2c++;
        if (g2c == 1) pos_p2 = 8'hDD; else req_p2 = 1'b0;
      end
    end
    check("rr_grants", n_gnt, 4);
    seen = 0;
    repeat (20) begin cyc(1); if (gnt_p1 === 1'b1) seen++; end
    check("fifth_waits", seen, 0);
    repeat (FUSE - 1) do_tick();
    cyc(3);
    for (int i = 0; i < 4; i++) begin
      build_model(rr_pos[i], 3'd1); push_exp(); c_cells[i] = m_addr;
    end
    do_tick();
    wait_idle("rr_exp");
    check("fifth_still_waits", seen + int'(sb.size()), 0);
    repeat (HOLD - 1) do_tick();
    cyc(3);
    for (int i = 0; i < 4; i++) push_clr(c_cells[i]);
    push_w(8'h33, 2, 1'b1, 1'b0);
    do_tick();
    t = 0;
    while (gnt_p1 !== 1'b1 && t < 300) begin cyc(1); t++; end
    check("fifth_granted", int'(t < 300), 1);
    cyc(1);
    req_p1 = 1'b0;
    wait_idle("rr_clr");
    check("rr_sb_drained", sb.size(), 0);

    // Chain reaction: A's right arm reaches B before B's own fuse runs out
    do_reset();
    place(1'b0, 8'h88, 3'd2);
    do_tick();
    place(1'b1, 8'h8A, 3'd1);
    repeat (FUSE - 2) do_tick();
    cyc(3);
    build_model(8'h88, 3'd2); push_exp(); a_cells = m_addr;
    build_model(8'h8A, 3'd1); push_exp(); b_cells = m_addr;
    do_tick();
    wait_idle("chain_exp");
    check("chain_both_exploded", sb.size(), 0);
    repeat (HOLD - 1) do_tick();
    cyc(3);
    push_clr(a_cells); push_clr(b_cells);
    do_tick();
    wait_idle("chain_clr");
    check("chain_sb_drained", sb.size(), 0);

    // Reset in the middle of an explosion
    do_reset();
    place(1'b0, 8'h88, 3'd2);
    repeat (FUSE - 1) do_tick();
    cyc(3);
    build_model(8'h88, 3'd2); push_exp();
    do_tick();
    cyc(1);
    reset_n = 1'b0;
    cyc(1);
    check("midexp_reset_wr_en", int'(wr_en), 0);
    check("midexp_reset_busy", int'(busy), 0);
    sb.delete();
    reset_n = 1'b1;
    bomb_cycle("after_reset", 1'b1, 8'h88, 3'd1);

    // Randomised single bombs over random wall maps
    do_reset();
    for (int it = 0; it < 10; it++) begin
      foreach (wall_map[i]) wall_map[i] = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      bomb_cycle("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
